// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the mul_arbiter block.
// Signed operation is selected at build time with MUL_ARBITER_SIGNED_EN.
package mul_arbiter_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  localparam int MUL_ITER = 8;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // Magnitude of a two's complement operand; -128 maps to 0x80, which is
  // still the correct magnitude when read as unsigned.
  function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? ((~v) + OP_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and result handshake bundle for mul_arbiter.
// master: requesters plus result consumer; slave: the arbiter.
interface mul_arbiter_if;
  import mul_arbiter_pkg::*;

  logic [1:0]        req_valid;
  logic [OP_W-1:0]   req_a0;
  logic [OP_W-1:0]   req_b0;
  logic [OP_W-1:0]   req_a1;
  logic [OP_W-1:0]   req_b1;
  logic [1:0]        req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [PROD_W-1:0] res_data;
  logic              res_id;
  logic              busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/mul_seq8.sv
// Iterative 8x8 shift-add multiplier datapath, one partial product per step.
// 'product' is the value the accumulator takes on the current edge, so the
// full result is visible together with 'last' on the eighth step.
module mul_seq8
  import mul_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product,
  output logic              last
);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Load fresh operands or perform one shift-add step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  assign product = acc_d;
  assign last    = step && !load && (cnt_q == CNT_W'(MUL_ITER - 1));

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mul_seq8 between two requesters.
// Optional macro MUL_ARBITER_SIGNED_EN: two's complement operands/product.
module mul_arbiter
  import mul_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic              res_valid_q, res_valid_d;
  logic              res_id_q, res_id_d;
  logic              busy_q, busy_d;
  logic [PROD_W-1:0] res_data_q, res_data_d;

  logic              grant;
  logic [1:0]        ready;
  logic              load;
  logic              step;
  logic              last;
  logic [OP_W-1:0]   sel_a, sel_b;
  logic [OP_W-1:0]   op_a, op_b;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] final_prod;

  // Pick the requester: a lone requester wins, a tie goes to the pointer.
  // Ready is held low during reset so the port reads zero while rst_n is low.
  always_comb begin
    grant = ptr_q;
    if (bus.req_valid == 2'b01)      grant = 1'b0;
    else if (bus.req_valid == 2'b10) grant = 1'b1;
    ready = 2'b00;
    if (rst_n && (state_q == IDLE) && (bus.req_valid != 2'b00)) ready[grant] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign load  = |ready;
  assign sel_a = grant ? bus.req_a1 : bus.req_a0;
  assign sel_b = grant ? bus.req_b1 : bus.req_b0;

`ifdef MUL_ARBITER_SIGNED_EN
  logic sign_q, sign_d;

  assign op_a       = abs_op(sel_a);
  assign op_b       = abs_op(sel_b);
  assign final_prod = sign_q ? ((~product) + PROD_W'(1)) : product;

  // Sign of the product in flight, captured at acceptance.
  always_comb begin
    sign_d = sign_q;
    if (load) sign_d = sel_a[OP_W-1] ^ sel_b[OP_W-1];
  end

  // Sign register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end
`else
  assign op_a       = sel_a;
  assign op_b       = sel_b;
  assign final_prod = product;
`endif

  mul_seq8 u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (op_a),
    .b       (op_b),
    .product (product),
    .last    (last)
  );

  // Control FSM: accept in IDLE, iterate in MUL, hold the result in DONE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = MUL;
          ptr_d   = ~grant;
          id_d    = grant;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = final_prod;
          res_id_d    = id_q;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = busy_q;

endmodule
